mips_data_bridge: RTL

Sequential bridge between the Harvard CPU's combinational data port and a wait-state data memory on an Avalon-style bus. Every CPU load/store is turned into a bus transaction, and the CPU is stalled through its `clk_enable` until the bus completes. Load data is registered and returned on a single commit cycle. Sits directly downstream of the CPU data port; its `cpu_clk_enable` output drives the CPU's `clk_enable` input.

---
 rtl/mips_bus_pkg.sv | 15 +
 rtl/mips_data_bridge.sv | 132 +++++++++++++
 2 files changed

// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the CPU data-port to Avalon bridge.
// Imported by mips_data_bridge.
package mips_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } bridge_state_t;

    localparam logic [3:0] BYTEEN_WORD = 4'hF;
    localparam int         WAIT_CNT_W  = 16;

endpackage

// File: rtl/mips_data_bridge.sv
// Stalls the CPU through clk_enable while each load/store runs on the bus.
// Optional MIPS_DATA_BRIDGE_ALIGN_CHECK_EN rejects misaligned accesses.
module mips_data_bridge
    import mips_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable_in,
    input  logic [31:0] cpu_data_address,
    input  logic        cpu_data_read,
    input  logic        cpu_data_write,
    input  logic [31:0] cpu_data_writedata,
    output logic [31:0] cpu_data_readdata,
    output logic        cpu_clk_enable,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    output logic [3:0]  mem_byteenable,
    input  logic        mem_waitrequest,
    input  logic [31:0] mem_readdata,
    output logic        bus_error,
    output logic        align_error
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST =
        WAIT_CNT_W'(TIMEOUT_CYCLES - 1);

    bridge_state_t         state;
    bridge_state_t         state_n;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic                  req;
    logic                  accept;
    logic                  misaligned;
    logic                  on_bus;
    logic                  timeout_hit;

    assign req         = cpu_data_read | cpu_data_write;
    assign accept      = (state == IDLE) && clk_enable_in && req;
    assign on_bus      = (state == READ) || (state == WRITE);
    assign timeout_hit = mem_waitrequest && (wait_cnt == WAIT_LAST);

    assign mem_byteenable = BYTEEN_WORD;

`ifdef MIPS_DATA_BRIDGE_ALIGN_CHECK_EN
    assign misaligned = cpu_data_address[1:0] != 2'b00;

    always_ff @(posedge clk) begin
        if (reset) begin
            align_error <= 1'b0;
        end else if (accept && misaligned) begin
            align_error <= 1'b1;
        end
    end
`else
    logic unused_low_bits;
    assign unused_low_bits = ^cpu_data_address[1:0];
    assign misaligned      = 1'b0;
    assign align_error     = 1'b0;
`endif

    always_comb begin
        state_n        = state;
        cpu_clk_enable = 1'b0;
        unique case (state)
            IDLE: begin
                cpu_clk_enable = clk_enable_in & ~req;
                if (accept) begin
                    if (misaligned) begin
                        state_n = DONE;
                    end else if (cpu_data_write) begin
                        state_n = WRITE;
                    end else begin
                        state_n = READ;
                    end
                end
            end
            READ, WRITE: begin
                // The slave is never frozen, so the enable is ignored here.
                if (!mem_waitrequest || timeout_hit) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                cpu_clk_enable = clk_enable_in;
                if (clk_enable_in) begin
                    state_n = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            wait_cnt          <= '0;
            mem_read          <= 1'b0;
            mem_write         <= 1'b0;
            mem_address       <= '0;
            mem_writedata     <= '0;
            cpu_data_readdata <= '0;
            bus_error         <= 1'b0;
        end else begin
            state     <= state_n;
            mem_read  <= state_n == READ;
            mem_write <= state_n == WRITE;
            if (accept) begin
                mem_address   <= {cpu_data_address[31:2], 2'b00};
                mem_writedata <= cpu_data_writedata;
                wait_cnt      <= '0;
                if (misaligned) begin
                    cpu_data_readdata <= '0;
                end
            end
            if (on_bus) begin
                if (!mem_waitrequest) begin
                    if (state == READ) begin
                        cpu_data_readdata <= mem_readdata;
                    end
                end else if (timeout_hit) begin
                    bus_error         <= 1'b1;
                    cpu_data_readdata <= '0;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end
        end
    end

endmodule
